// File: rtl/nibble_sub_seq_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM states, slice width,
// and the counter sizing helper.
package nibble_sub_seq_pkg;

  localparam int unsigned NIBW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/full_sub_4bits.sv
// 4-bit borrow-lookahead subtract slice: D = X - Y - B0, with group
// generate/propagate for optional higher-level lookahead.
module full_sub_4bits (
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       B0,
  output logic [3:0] D,
  output logic       B4,
  output logic       Gm,
  output logic       Pm
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_b;

  // A bit generates a borrow when x=0,y=1; equal bits pass the incoming borrow.
  assign w_g = ~X & Y;
  assign w_p = ~(X ^ Y);

  assign w_b[0] = B0;
  assign w_b[1] = w_g[0] | (w_p[0] & B0);
  assign w_b[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & B0);
  assign w_b[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & B0);

  assign Gm = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign Pm = &w_p;
  assign B4 = Gm | (Pm & B0);

  assign D = X ^ Y ^ w_b;

endmodule

// File: rtl/nibble_sub_seq.sv
// Multi-cycle WIDTH-bit subtractor/comparator: one shared 4-bit slice processes
// a nibble per cycle (LSB first) with the borrow chained through a register.
module nibble_sub_seq
  import nibble_sub_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ltu,
  output logic             lt,
  output logic             ovf
);

  localparam int unsigned NIB  = WIDTH / NIBW;
  localparam int unsigned CW   = clog2(NIB);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_zero;
  logic             r_lt;
  logic             r_ovf;

  logic [NIBW-1:0]  w_a_nib;
  logic [NIBW-1:0]  w_b_nib;
  logic [NIBW-1:0]  w_d;
  logic             w_b4;
  logic [WIDTH-1:0] w_diff_full;
  logic             w_ovf;

  assign w_a_nib = r_a[NIBW*r_cnt +: NIBW];
  assign w_b_nib = r_b[NIBW*r_cnt +: NIBW];

  full_sub_4bits u_slice (
    .X  (w_a_nib),
    .Y  (w_b_nib),
    .B0 (r_borrow),
    .D  (w_d),
    .B4 (w_b4),
    .Gm (),
    .Pm ()
  );

  // On the last nibble the lower nibbles are already in r_diff; splice the
  // top nibble in so the flags see the complete result in the same cycle.
  assign w_diff_full = {w_d, r_diff[WIDTH-NIBW-1:0]};
  assign w_ovf       = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                       (w_diff_full[WIDTH-1] != r_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_lt     <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_diff[NIBW*r_cnt +: NIBW] <= w_d;
          r_borrow <= w_b4;
          if (r_cnt == LAST) begin
            r_bout  <= w_b4;
            r_zero  <= (w_diff_full == '0);
            r_ovf   <= w_ovf;
            r_lt    <= w_diff_full[WIDTH-1] ^ w_ovf;
            r_cnt   <= '0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ltu       = r_bout;
  assign zero      = r_zero;
  assign lt        = r_lt;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_sub_seq.sv
// Self-checking bench for nibble_sub_seq: directed vectors, backpressure,
// reset/flush aborts and randomized operations against an arithmetic model.
module tb_nibble_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] diff;
  logic        bout, zero, ltu, lt, ovf;

  int n_checks = 0;
  int n_errors = 0;

  nibble_sub_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .ltu       (ltu),
    .lt        (lt),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic, not a nibble-level re-implementation.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin,
                       output logic [31:0] ed, output logic eb, output logic ez,
                       output logic elt, output logic eov);
    logic signed [33:0] sa, sb, sd;
    logic [32:0] ud;
    ud  = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
    ed  = ud[31:0];
    eb  = ({1'b0, ma} < ({1'b0, mb} + {32'd0, mbin}));
    ez  = (ed == 32'd0);
    sa  = {{2{ma[31]}}, ma};
    sb  = {{2{mb[31]}}, mb};
    sd  = sa - sb - $signed({33'd0, mbin});
    elt = (sd < 0);
    eov = (sd > 34'sd2147483647) || (sd < -34'sd2147483648);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_b, input logic tbin,
                        input int hold);
    logic [31:0] ed;
    logic eb, ez, elt, eov;
    int cyc;
    model(ta, tb_b, tbin, ed, eb, ez, elt, eov);
    chk("in_ready_before", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; a = ta; b = tb_b; bin = tbin;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      a = $urandom; b = $urandom; bin = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, 32'd8);
    chk("diff", diff, ed);
    chk("bout", {31'd0, bout}, {31'd0, eb});
    chk("ltu", {31'd0, ltu}, {31'd0, eb});
    chk("zero", {31'd0, zero}, {31'd0, ez});
    chk("lt", {31'd0, lt}, {31'd0, elt});
    chk("ovf", {31'd0, ovf}, {31'd0, eov});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_diff", diff, ed);
      chk("hold_flags", {27'd0, bout, ltu, zero, lt, ovf}, {27'd0, eb, eb, ez, elt, eov});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", {31'd0, out_valid}, 32'd0);
    chk("release_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_b);
    in_valid = 1'b1; a = ta; b = tb_b; bin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic no_result(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd0);
    chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_diff", diff, 32'd0);
    chk("rst_flags", {27'd0, bout, ltu, zero, lt, ovf}, 32'd0);
    // Request during reset must not be taken.
    in_valid = 1'b1; a = 32'h5; b = 32'h3;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_noaccept", {31'd0, in_ready}, 32'd1);

    run_op(32'h00000005, 32'h00000003, 1'b0, 0);
    run_op(32'h00000003, 32'h00000005, 1'b0, 0);
    run_op(32'h80000000, 32'h00000001, 1'b0, 0);
    run_op(32'h12345678, 32'h12345678, 1'b0, 0);
    run_op(32'h12345678, 32'h12345678, 1'b1, 0);
    run_op(32'h00000000, 32'h00000001, 1'b0, 0);
    run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 5);
    run_op(32'h0000ABCD, 32'h00001234, 1'b0, 0);

    // Reset mid-RUN.
    start_op(32'hFFFFFFFF, 32'h00000001);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_diff", diff, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    no_result("rst_abort");
    run_op(32'd10, 32'd20, 1'b0, 0);

    // Flush mid-RUN.
    start_op(32'hFFFFFFFF, 32'h00000001);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    no_result("flush_abort");
    run_op(32'd10, 32'd20, 1'b0, 0);

    // Flush wins over in_valid in IDLE.
    flush = 1'b1; in_valid = 1'b1; a = 32'h1; b = 32'h2;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_prio", {31'd0, in_ready}, 32'd1);

    // Flush in DONE drops out_valid but leaves the result visible.
    start_op(32'h00000100, 32'h00000001);
    repeat (8) @(negedge clk);
    chk("done_pre_flush", {31'd0, out_valid}, 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    chk("done_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("done_flush_diff", diff, 32'h000000FF);

    for (int k = 0; k < 30; k++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (k % 5 == 0) ? ra : $urandom;
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
